tile_miss_issue: RTL and testbench

TILE_MISS_ISSUE -- requirements
Module: tile_miss_issue

---
 rtl/tile_miss_issue.sv | 179 +++++++++++++++++
 tb/tb_tile_miss_issue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tile_miss_issue.sv
// Purpose : collects up to three miss requests per cycle into a small FIFO and issues
//           up to three per cycle downstream, tracking issued lines until their fill returns.
// Latency : accept at edge E issues at edge E+1 at the earliest (no bypass).
//           Backpressure: req_ready drops when fewer than 3 FIFO slots are free, and issue
//           pauses on issue_stall or when the outstanding table has no free slot.
// Ports   : clk, rst (sync, active-high); req_en/req_addr/req_phy/req_ready (3-lane request side);
//           issue_stall, missue_en/missue_addr/missue_phy (issue side, registered);
//           fill_en/fill_addr (line return); outst_full (all table slots busy).
// Build   : define MISS_COALESCE_EN to drop requests whose line is already queued or outstanding.
module tile_miss_issue #(
  parameter int DEPTH = 8,
  parameter int OUTST = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req_en,
  input  logic [2:0][38:0] req_addr,
  input  logic [2:0][39:0] req_phy,
  output logic             req_ready,
  input  logic             issue_stall,
  output logic [2:0]       missue_en,
  output logic [2:0][38:0] missue_addr,
  output logic [2:0][39:0] missue_phy,
  input  logic             fill_en,
  input  logic [38:0]      fill_addr,
  output logic             outst_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [38:0]      fifo_addr_q [DEPTH];
  logic [38:0]      fifo_addr_d [DEPTH];
  logic [39:0]      fifo_phy_q  [DEPTH];
  logic [39:0]      fifo_phy_d  [DEPTH];
  logic [OUTST-1:0] tv_q, tv_d;          // outstanding table valid bits
  logic [38:0]      ta_q [OUTST];        // outstanding table line addresses
  logic [38:0]      ta_d [OUTST];
  logic [2:0]       men_q, men_d;
  logic [2:0][38:0] maddr_q, maddr_d;
  logic [2:0][39:0] mphy_q, mphy_d;

  logic [2:0]       acc;
  logic [OUTST-1:0] taken;
  logic [AW-1:0]    pidx, wp;
  logic             found, hit;
  int               free_cnt, n_pop, n_push;

  // Count never exceeds DEPTH, so DEPTH-3 fits in CW bits (DEPTH >= 4).
  assign req_ready   = (count_q <= CW'(DEPTH - 3));
  assign outst_full  = &tv_q;
  assign missue_en   = men_q;
  assign missue_addr = maddr_q;
  assign missue_phy  = mphy_q;

`ifdef MISS_COALESCE_EN
  // Occupied FIFO slots: offset from the read pointer is below the count.
  // Entries being issued this edge are still occupied, so they are covered here too.
  logic [DEPTH-1:0] ent_vld;
  always_comb begin
    ent_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i] = ({1'b0, AW'(i) - rd_ptr_q} < count_q);
    end
  end
`endif

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_phy_d  = fifo_phy_q;
    tv_d        = tv_q;
    ta_d        = ta_q;
    men_d       = '0;
    maddr_d     = maddr_q;
    mphy_d      = mphy_q;
    taken       = tv_q;
    pidx        = rd_ptr_q;
    wp          = wr_ptr_q;
    found       = 1'b0;
    hit         = 1'b0;
    free_cnt    = 0;
    n_pop       = 3;
    n_push      = 0;

    acc = req_ready ? req_en : 3'b000;
`ifdef MISS_COALESCE_EN
    for (int l = 0; l < 3; l++) begin
      for (int k = 0; k < l; k++) begin
        if (req_en[k] && (req_addr[k] == req_addr[l])) acc[l] = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld[i] && (fifo_addr_q[i] == req_addr[l])) acc[l] = 1'b0;
      end
      for (int j = 0; j < OUTST; j++) begin
        if (tv_q[j] && (ta_q[j] == req_addr[l])) acc[l] = 1'b0;
      end
    end
`endif

    // Issue width: bounded by queued entries, lane count and free table slots.
    // Free slots are counted before this edge's fill so a freed slot waits a cycle.
    for (int j = 0; j < OUTST; j++) begin
      if (!tv_q[j]) free_cnt = free_cnt + 1;
    end
    if (int'(count_q) < n_pop) n_pop = int'(count_q);
    if (free_cnt < n_pop)      n_pop = free_cnt;
    if (issue_stall)           n_pop = 0;

    for (int k = 0; k < 3; k++) begin
      if (k < n_pop) begin
        pidx       = rd_ptr_q + AW'(k);
        men_d[k]   = 1'b1;
        maddr_d[k] = fifo_addr_q[pidx];
        mphy_d[k]  = fifo_phy_q[pidx];
        found      = 1'b0;
        for (int j = 0; j < OUTST; j++) begin
          if (!found && !taken[j]) begin
            found    = 1'b1;
            taken[j] = 1'b1;
            tv_d[j]  = 1'b1;
            ta_d[j]  = fifo_addr_q[pidx];
          end
        end
      end
    end

    // Fill only matches slots valid before this edge, so it never collides with allocation.
    for (int j = 0; j < OUTST; j++) begin
      if (fill_en && !hit && tv_q[j] && (ta_q[j] == fill_addr)) begin
        hit     = 1'b1;
        tv_d[j] = 1'b0;
      end
    end

    // Accepted lanes land compacted at consecutive slots in lane order.
    for (int l = 0; l < 3; l++) begin
      if (acc[l]) begin
        fifo_addr_d[wp] = req_addr[l];
        fifo_phy_d[wp]  = req_phy[l];
        wp              = wp + AW'(1);
        n_push          = n_push + 1;
      end
    end

    wr_ptr_d = wp;
    rd_ptr_d = rd_ptr_q + AW'(n_pop);
    count_d  = count_q + CW'(n_push) - CW'(n_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tv_q     <= '0;
      men_q    <= '0;
      maddr_q  <= '0;
      mphy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tv_q     <= tv_d;
      men_q    <= men_d;
      maddr_q  <= maddr_d;
      mphy_q   <= mphy_d;
    end
  end

  // Payload storage needs no reset: validity comes from pointers/count and tv_q.
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_phy_q  <= fifo_phy_d;
    ta_q        <= ta_d;
  end

endmodule

// File: tb/tb_tile_miss_issue.sv
module tb_tile_miss_issue;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req_en;
  logic [2:0][38:0] req_addr;
  logic [2:0][39:0] req_phy;
  logic             req_ready;
  logic             issue_stall;
  logic [2:0]       missue_en;
  logic [2:0][38:0] missue_addr;
  logic [2:0][39:0] missue_phy;
  logic             fill_en;
  logic [38:0]      fill_addr;
  logic             outst_full;

  int n_vec = 0;
  int n_err = 0;

  tile_miss_issue #(.DEPTH(8), .OUTST(8)) dut (
    .clk(clk), .rst(rst),
    .req_en(req_en), .req_addr(req_addr), .req_phy(req_phy), .req_ready(req_ready),
    .issue_stall(issue_stall),
    .missue_en(missue_en), .missue_addr(missue_addr), .missue_phy(missue_phy),
    .fill_en(fill_en), .fill_addr(fill_addr), .outst_full(outst_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lanes(input logic [2:0] en, input logic [38:0] a0, input logic [38:0] a1,
                       input logic [38:0] a2);
    req_en      = en;
    req_addr[0] = a0;
    req_addr[1] = a1;
    req_addr[2] = a2;
    req_phy[0]  = {1'b1, a0};
    req_phy[1]  = {1'b1, a1};
    req_phy[2]  = {1'b1, a2};
  endtask

  task automatic fill(input logic [38:0] a);
    fill_en   = 1'b1;
    fill_addr = a;
    tick();
    fill_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; issue_stall = 1'b0; fill_en = 1'b0; fill_addr = '0;
    lanes(3'b000, '0, '0, '0);
    tick();
    chk("ready_in_reset", req_ready, 1);
    chk("full_in_reset", outst_full, 0);
    tick();
    chk("en_reset", missue_en, 0);
    chk("addr0_reset", missue_addr[0], 0);
    chk("phy0_reset", missue_phy[0], 0);

    // Single miss: visible exactly one edge after accept.
    rst = 1'b0;
    lanes(3'b001, 39'h10, '0, '0);
    tick();
    lanes(3'b000, '0, '0, '0);
    chk("single_no_bypass", missue_en, 0);
    tick();
    chk("single_en", missue_en, 3'b001);
    chk("single_addr", missue_addr[0], 39'h10);
    chk("single_phy", missue_phy[0], {1'b1, 39'h10});
    tick();
    chk("single_pulse", missue_en, 0);
    chk("single_hold", missue_addr[0], 39'h10);
    fill(39'h10);

    // Duplicate addresses in one burst.
    lanes(3'b111, 39'h20, 39'h20, 39'h30);
    tick();
    lanes(3'b000, '0, '0, '0);
    tick();
`ifdef MISS_COALESCE_EN
    chk("dup_en", missue_en, 3'b011);
    chk("dup_a0", missue_addr[0], 39'h20);
    chk("dup_a1", missue_addr[1], 39'h30);
`else
    chk("dup_en", missue_en, 3'b111);
    chk("dup_a0", missue_addr[0], 39'h20);
    chk("dup_a1", missue_addr[1], 39'h20);
    chk("dup_a2", missue_addr[2], 39'h30);
`endif
    fill(39'h20);
    fill(39'h20);
    fill(39'h30);
    chk("dup_cleared", outst_full, 0);

    // Stalled fill-up: ready drops at count 6, the held burst is not taken.
    issue_stall = 1'b1;
    lanes(3'b111, 39'h100, 39'h101, 39'h102);
    tick();
    chk("stall_ready3", req_ready, 1);
    chk("stall_en3", missue_en, 0);
    lanes(3'b111, 39'h103, 39'h104, 39'h105);
    tick();
    chk("stall_ready6", req_ready, 0);
    lanes(3'b111, 39'h106, 39'h107, 39'h108);
    tick();
    chk("held_ready", req_ready, 0);
    chk("held_en", missue_en, 0);
    issue_stall = 1'b0;
    tick();
    lanes(3'b000, '0, '0, '0);
    chk("drain1_en", missue_en, 3'b111);
    chk("drain1_a0", missue_addr[0], 39'h100);
    chk("drain1_a2", missue_addr[2], 39'h102);
    chk("drain1_ready", req_ready, 1);
    tick();
    chk("drain2_en", missue_en, 3'b111);
    chk("drain2_a0", missue_addr[0], 39'h103);
    chk("drain2_a2", missue_addr[2], 39'h105);
    tick();
    chk("held_never_taken", missue_en, 0);

    // Table fills to 8; a fill frees a slot usable only on the following edge.
    lanes(3'b111, 39'h200, 39'h201, 39'h202);
    tick();
    lanes(3'b000, '0, '0, '0);
    tick();
    chk("tbl_en", missue_en, 3'b011);
    chk("tbl_a0", missue_addr[0], 39'h200);
    chk("tbl_a1", missue_addr[1], 39'h201);
    chk("tbl_full", outst_full, 1);
    tick();
    chk("tbl_blocked", missue_en, 0);
    fill(39'h100);
    chk("fill_edge_en", missue_en, 0);
    chk("fill_edge_full", outst_full, 0);
    tick();
    chk("after_fill_en", missue_en, 3'b001);
    chk("after_fill_a0", missue_addr[0], 39'h202);
    chk("after_fill_full", outst_full, 1);

    // Reset mid-stream: 4 valid slots, count 5, plus a fill and requests on the reset edge.
    fill(39'h101);
    fill(39'h102);
    fill(39'h103);
    fill(39'h104);
    chk("four_valid_full", outst_full, 0);
    issue_stall = 1'b1;
    lanes(3'b111, 39'h400, 39'h401, 39'h402);
    tick();
    lanes(3'b011, 39'h403, 39'h404, '0);
    tick();
    chk("count5_ready", req_ready, 1);
    rst = 1'b1; fill_en = 1'b1; fill_addr = 39'h105;
    lanes(3'b111, 39'h500, 39'h501, 39'h502);
    tick();
    chk("rst_en", missue_en, 0);
    chk("rst_full", outst_full, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_addr0", missue_addr[0], 0);
    rst = 1'b0; fill_en = 1'b0; issue_stall = 1'b0;
    lanes(3'b000, '0, '0, '0);
    tick();
    chk("post_rst_empty", missue_en, 0);

    // Eight fresh misses: table must have been fully cleared by reset.
    lanes(3'b111, 39'h300, 39'h301, 39'h302);
    tick();
    lanes(3'b111, 39'h303, 39'h304, 39'h305);
    tick();
    chk("fresh1_en", missue_en, 3'b111);
    chk("fresh1_a0", missue_addr[0], 39'h300);
    lanes(3'b011, 39'h306, 39'h307, '0);
    tick();
    lanes(3'b000, '0, '0, '0);
    chk("fresh2_en", missue_en, 3'b111);
    chk("fresh2_a0", missue_addr[0], 39'h303);
    chk("fresh2_full", outst_full, 0);
    tick();
    chk("fresh3_en", missue_en, 3'b011);
    chk("fresh3_a0", missue_addr[0], 39'h306);
    chk("fresh3_a1", missue_addr[1], 39'h307);
    chk("fresh3_phy1", missue_phy[1], {1'b1, 39'h307});
    chk("fresh3_full", outst_full, 1);
    tick();
    chk("fresh_idle", missue_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
